// File: rtl/lsq_issue_if.sv
// Issue, memory and result channels of the load/store queue.
// The slave modport is the queue itself; the master modport is its environment.
interface lsq_issue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic             in_is_store;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      in_address;
    logic [31:0]      in_wdata;

    logic [31:0]      mem_address;
    logic [31:0]      mem_writedata;
    logic             mem_memread;
    logic             mem_memwrite;
    logic [31:0]      mem_readdata;

    logic             res_valid;
    logic             res_ready;
    logic [TAG_W-1:0] res_tag;
    logic             res_is_store;
    logic [31:0]      res_data;
    logic             res_exc;

    logic [CNT_W-1:0] count;

    modport slave (
        input  in_valid, in_is_store, in_tag, in_address, in_wdata,
        input  mem_readdata, res_ready,
        output in_ready, mem_address, mem_writedata, mem_memread, mem_memwrite,
        output res_valid, res_tag, res_is_store, res_data, res_exc, count
    );

    modport master (
        output in_valid, in_is_store, in_tag, in_address, in_wdata,
        output mem_readdata, res_ready,
        input  in_ready, mem_address, mem_writedata, mem_memread, mem_memwrite,
        input  res_valid, res_tag, res_is_store, res_data, res_exc, count
    );
endinterface

// File: rtl/lsq_issue.sv
// In-order load/store queue feeding a word-addressed data memory one op per cycle,
// with a single backpressured result slot and address-exception detection.
module lsq_issue #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned MEM_WORDS = 128
) (
    input logic        clk,
    input logic        reset,
    input logic        flush,
    lsq_issue_if.slave bus
);
    localparam int unsigned PTR_W      = $clog2(DEPTH);
    localparam int unsigned CNT_W      = $clog2(DEPTH + 1);
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             entry_store_q [DEPTH];
    logic [TAG_W-1:0] entry_tag_q   [DEPTH];
    logic [31:0]      entry_addr_q  [DEPTH];
    logic [31:0]      entry_wdata_q [DEPTH];

    logic             res_valid_q, res_valid_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic             res_is_store_q, res_is_store_d;
    logic [31:0]      res_data_q, res_data_d;
    logic             res_exc_q, res_exc_d;

    logic        enq;
    logic        issue;
    logic        head_store;
    logic        head_exc;
    logic [31:0] head_addr;

    assign head_addr  = entry_addr_q[head_q];
    assign head_store = entry_store_q[head_q];
    assign head_exc   = (head_addr[1:0] != 2'b00) | ({1'b0, head_addr} >= ADDR_LIMIT);

    // No bypass: a full queue refuses input even while it is dequeuing.
    assign bus.in_ready = (count_q != CNT_W'(DEPTH));
    assign enq          = bus.in_valid & bus.in_ready & ~flush;
    // Reset also blocks issue so no store can commit while the queue is being cleared.
    assign issue        = (count_q != '0) & (~res_valid_q | bus.res_ready) & ~flush & ~reset;

    assign bus.mem_address   = head_addr;
    assign bus.mem_writedata = entry_wdata_q[head_q];
    assign bus.mem_memread   = issue & ~head_store & ~head_exc;
    assign bus.mem_memwrite  = issue & head_store & ~head_exc;

    assign bus.res_valid    = res_valid_q;
    assign bus.res_tag      = res_tag_q;
    assign bus.res_is_store = res_is_store_q;
    assign bus.res_data     = res_data_q;
    assign bus.res_exc      = res_exc_q;
    assign bus.count        = count_q;

    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        res_valid_d    = res_valid_q;
        res_tag_d      = res_tag_q;
        res_is_store_d = res_is_store_q;
        res_data_d     = res_data_q;
        res_exc_d      = res_exc_q;

        if (enq) begin
            tail_d = tail_q + PTR_W'(1);
        end

        if (issue) begin
            head_d         = head_q + PTR_W'(1);
            res_valid_d    = 1'b1;
            res_tag_d      = entry_tag_q[head_q];
            res_is_store_d = head_store;
            res_exc_d      = head_exc;
            res_data_d     = (~head_store & ~head_exc) ? bus.mem_readdata : 32'd0;
        end else if (res_valid_q & bus.res_ready) begin
            res_valid_d = 1'b0;
        end

        case ({enq, issue})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset | flush) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            res_valid_q    <= 1'b0;
            res_tag_q      <= '0;
            res_is_store_q <= 1'b0;
            res_data_q     <= '0;
            res_exc_q      <= 1'b0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            res_valid_q    <= res_valid_d;
            res_tag_q      <= res_tag_d;
            res_is_store_q <= res_is_store_d;
            res_data_q     <= res_data_d;
            res_exc_q      <= res_exc_d;
        end
    end

    // Entry payload needs no reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (enq) begin
            entry_store_q[tail_q] <= bus.in_is_store;
            entry_tag_q[tail_q]   <= bus.in_tag;
            entry_addr_q[tail_q]  <= bus.in_address;
            entry_wdata_q[tail_q] <= bus.in_wdata;
        end
    end
endmodule

// File: tb/tb_lsq_issue.sv
// Bench for lsq_issue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_lsq_issue;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned TAG_W     = 4;
    localparam int unsigned MEM_WORDS = 128;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    lsq_issue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

    lsq_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .MEM_WORDS(MEM_WORDS)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory seen by the DUT
    logic [31:0] mem [MEM_WORDS];
    assign bus.mem_readdata = mem[bus.mem_address[8:2]];
    always @(posedge clk) begin
        if (bus.mem_memwrite) mem[bus.mem_address[8:2]] <= bus.mem_writedata;
    end

    // Reference model: a FIFO of ops, a result slot and a private memory image
    typedef struct {
        bit          st;
        logic [3:0]  tag;
        logic [31:0] a;
        logic [31:0] d;
    } op_t;

    op_t         q[$];
    bit          m_valid = 0;
    logic [3:0]  m_tag;
    bit          m_st;
    bit          m_exc;
    logic [31:0] m_data;
    logic [31:0] ref_mem [MEM_WORDS];
    bit          armed = 0;

    function automatic bit is_exc(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'(4 * MEM_WORDS));
    endfunction

    always @(posedge clk) begin : model
        bit  do_iss;
        bit  do_enq;
        op_t h;
        op_t n;
        if (reset) begin
            q.delete();
            m_valid = 0;
            armed   = 1;
        end else if (flush) begin
            q.delete();
            m_valid = 0;
        end else begin
            do_iss = (q.size() != 0) && (!m_valid || bus.res_ready);
            do_enq = bus.in_valid && (q.size() < int'(DEPTH));
            n.st  = bus.in_is_store;
            n.tag = bus.in_tag;
            n.a   = bus.in_address;
            n.d   = bus.in_wdata;
            if (do_iss) begin
                h       = q.pop_front();
                m_valid = 1;
                m_tag   = h.tag;
                m_st    = h.st;
                m_exc   = is_exc(h.a);
                m_data  = 32'd0;
                if (!m_exc) begin
                    if (h.st) ref_mem[h.a[8:2]] = h.d;
                    else      m_data = ref_mem[h.a[8:2]];
                end
            end else if (m_valid && bus.res_ready) begin
                m_valid = 0;
            end
            if (do_enq) q.push_back(n);
        end
    end

    always @(negedge clk) begin : compare
        bit iss;
        if (armed) begin
            chk("count", 32'(bus.count), 32'(q.size()));
            chk("in_ready", 32'(bus.in_ready), 32'(q.size() != int'(DEPTH)));
            chk("res_valid", 32'(bus.res_valid), 32'(m_valid));
            if (m_valid) begin
                chk("res_tag", 32'(bus.res_tag), 32'(m_tag));
                chk("res_is_store", 32'(bus.res_is_store), 32'(m_st));
                chk("res_exc", 32'(bus.res_exc), 32'(m_exc));
                chk("res_data", bus.res_data, m_data);
            end
            iss = (q.size() != 0) && (!m_valid || bus.res_ready) && !flush && !reset;
            chk("mem_memread", 32'(bus.mem_memread),
                32'(iss && !q[0].st && !is_exc(q[0].a)));
            chk("mem_memwrite", 32'(bus.mem_memwrite),
                32'(iss && q[0].st && !is_exc(q[0].a)));
            if (iss) begin
                chk("mem_address", bus.mem_address, q[0].a);
                if (q[0].st) chk("mem_writedata", bus.mem_writedata, q[0].d);
            end
        end
    end

    task automatic push(input bit st, input logic [3:0] tag, input logic [31:0] a,
                        input logic [31:0] d);
        int n = 0;
        bus.in_valid    = 1'b1;
        bus.in_is_store = st;
        bus.in_tag      = tag;
        bus.in_address  = a;
        bus.in_wdata    = d;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("push_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [31:0] addr;
    int unsigned w;

    initial begin
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            mem[i]     = 32'(i);
            ref_mem[i] = 32'(i);
        end
        reset           = 1'b1;
        flush           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_is_store = 1'b0;
        bus.in_tag      = '0;
        bus.in_address  = '0;
        bus.in_wdata    = '0;
        bus.res_ready   = 1'b1;
        idle(2);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);

        // Single load
        push(0, 4'd1, 32'h10, 32'd0);
        @(negedge clk);
        chk("t1_memread", 32'(bus.mem_memread), 32'd1);
        @(negedge clk);
        chk("t1_valid", 32'(bus.res_valid), 32'd1);
        chk("t1_tag", 32'(bus.res_tag), 32'd1);
        chk("t1_data", bus.res_data, 32'd4);
        chk("t1_exc", 32'(bus.res_exc), 32'd0);
        idle(2);

        // Store then dependent load
        push(1, 4'd2, 32'h20, 32'hDEADBEEF);
        push(0, 4'd3, 32'h20, 32'd0);
        @(negedge clk);
        chk("t2_tag_st", 32'(bus.res_tag), 32'd2);
        chk("t2_is_store", 32'(bus.res_is_store), 32'd1);
        chk("t2_st_data", bus.res_data, 32'd0);
        @(negedge clk);
        chk("t2_tag_ld", 32'(bus.res_tag), 32'd3);
        chk("t2_ld_data", bus.res_data, 32'hDEADBEEF);
        idle(2);

        // Misaligned and out-of-range loads
        push(0, 4'd4, 32'h13, 32'd0);
        push(0, 4'd5, 32'h200, 32'd0);
        @(negedge clk);
        chk("t3_memread_a", 32'(bus.mem_memread), 32'd0);
        chk("t3_tag_a", 32'(bus.res_tag), 32'd4);
        chk("t3_exc_a", 32'(bus.res_exc), 32'd1);
        chk("t3_data_a", bus.res_data, 32'd0);
        @(negedge clk);
        chk("t3_memread_b", 32'(bus.mem_memread), 32'd0);
        chk("t3_tag_b", 32'(bus.res_tag), 32'd5);
        chk("t3_exc_b", 32'(bus.res_exc), 32'd1);
        idle(2);

        // Backpressure fills the queue
        bus.res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(0, 4'(6 + i), 32'(4 * i), 32'd0);
        @(negedge clk);
        chk("t4_count_full", 32'(bus.count), 32'd4);
        chk("t4_in_ready_lo", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("t4_no_bypass", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk("t4_in_ready_hi", 32'(bus.in_ready), 32'd1);
        idle(8);

        // Flush suppresses the head store
        bus.res_ready = 1'b0;
        push(0, 4'd8, 32'h0, 32'd0);
        push(1, 4'd9, 32'h40, 32'd7);
        push(0, 4'd10, 32'h44, 32'd0);
        push(0, 4'd11, 32'h48, 32'd0);
        flush         = 1'b1;
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("t5_memwrite", 32'(bus.mem_memwrite), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("t5_count", 32'(bus.count), 32'd0);
        chk("t5_res_valid", 32'(bus.res_valid), 32'd0);
        push(0, 4'd12, 32'h40, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("t5_tag", 32'(bus.res_tag), 32'd12);
        chk("t5_data", bus.res_data, 32'd16);
        idle(2);

        // Reset with a busy queue and full slot
        bus.res_ready = 1'b0;
        push(0, 4'd1, 32'h4, 32'd0);
        push(0, 4'd2, 32'h8, 32'd0);
        push(0, 4'd3, 32'hC, 32'd0);
        @(negedge clk);
        chk("t6_pre_count", 32'(bus.count), 32'd2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t6_count", 32'(bus.count), 32'd0);
        chk("t6_res_valid", 32'(bus.res_valid), 32'd0);
        chk("t6_in_ready", 32'(bus.in_ready), 32'd1);
        chk("t6_memread", 32'(bus.mem_memread), 32'd0);
        chk("t6_memwrite", 32'(bus.mem_memwrite), 32'd0);
        bus.res_ready = 1'b1;
        idle(2);

        // Random traffic: eager consumer, then a mostly stalled one
        for (int phase = 0; phase < 2; phase++) begin
            for (int c = 0; c < 1500; c++) begin
                @(posedge clk);
                #1;
                reset           = ($urandom_range(0, 199) == 0);
                flush           = ($urandom_range(0, 49) == 0);
                bus.res_ready   = (phase == 0) ? ($urandom_range(0, 3) != 0)
                                               : ($urandom_range(0, 3) == 0);
                bus.in_valid    = $urandom_range(0, 1) != 0;
                bus.in_is_store = ($urandom_range(0, 2) == 0);
                bus.in_tag      = 4'($urandom);
                bus.in_wdata    = $urandom;
                w               = $urandom_range(0, 7);
                case ($urandom_range(0, 15))
                    0:       addr = (32'(w) << 2) | 32'(1 + $urandom_range(0, 2));
                    1:       addr = 32'(4 * MEM_WORDS) + (32'(w) << 2);
                    default: addr = 32'(w) << 2;
                endcase
                bus.in_address = addr;
            end
        end
        @(posedge clk);
        #1;
        reset         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsq_issue.md
Name: lsq_issue

Overview:
- In-order load/store queue sitting directly upstream of the word-addressed data memory in the I2OI load/store stage.
- Accepts memory ops from issue, buffers them in program order, and drives the memory port one op per cycle.
- Registers load data and store completions into a single result slot with backpressure.
- Detects misaligned and out-of-range addresses; such ops never reach memory.

Parameters:
DEPTH, 4, queue entries (power of 2, >=2)
TAG_W, 4, width of op tag carried to result
MEM_WORDS, 128, words in downstream memory; legal byte addresses 0..4*MEM_WORDS-1

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  synchronous, active-high
flush  in  1  synchronous queue clear (pipeline squash)
in_valid  in  1  op offered
in_ready  out  1  queue can accept
in_is_store  in  1  1=store, 0=load
in_tag  in  TAG_W  op tag
in_address  in  32  byte address
in_wdata  in  32  store data
mem_address  out  32  to memory address
mem_writedata  out  32  to memory writedata
mem_memread  out  1  to memory memread
mem_memwrite  out  1  to memory memwrite
mem_readdata  in  32  combinational read data from memory
res_valid  out  1  result slot occupied
res_ready  in  1  consumer takes result
res_tag  out  TAG_W  tag of completed op
res_is_store  out  1  completed op was store
res_data  out  32  load data; 0 for stores/exceptions
res_exc  out  1  address exception
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Storage: circular buffer, head/tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, plus count register.
- Reset and flush clear the following to 0 on the next posedge: head, tail, count, res_valid, res_tag, res_is_store, res_data, res_exc.
- in_ready = (count != DEPTH). No same-cycle bypass: when full, in_ready stays low even if a dequeue occurs that cycle.
- enq = in_valid & in_ready & ~flush. Writes the entry at tail; tail increments.
- exc(head) = (address[1:0] != 0) | (address >= 4*MEM_WORDS).
- issue = (count != 0) & (~res_valid | res_ready) & ~flush.
- Memory port, combinational from the head entry:
  - mem_address = head address.
  - mem_writedata = head wdata.
  - mem_memread = issue & ~is_store & ~exc.
  - mem_memwrite = issue & is_store & ~exc.
  - When not issuing, both strobes are 0 and address/writedata hold the head values (don't-care).
- On posedge with issue:
  - Head dequeues; head increments.
  - Result slot loads tag, is_store and exc.
  - res_data = mem_readdata if load & ~exc, else 0.
  - res_valid = 1.
  - The store commits in memory on the same edge.
- On posedge with res_valid & res_ready & ~issue: res_valid clears; other result fields hold.
- count update: +1 on enq only, -1 on issue only, unchanged on both or neither.
- Latency:
  - Op accepted at edge t into an empty queue with a free slot is driven to memory during cycle t..t+1.
  - Its result is visible after edge t+1.
  - Sustained throughput is 1 op/cycle when res_ready is held high.
- Ordering: strictly in order, so a load behind a store to the same word returns the stored data.
- Reset has priority over flush; flush has priority over enq/issue. Flush mid-operation suppresses the head store (mem_memwrite=0 that cycle).

Test Plan:
- Reset, then load tag=1 addr 0x10, res_ready=1 -> mem_memread=1 for one cycle; next cycle res_valid=1, res_tag=1, res_data=4 (memory preloaded memory[i]=i), res_exc=0.
- Store 0x20 <= 0xDEADBEEF (tag 2), then back-to-back load 0x20 (tag 3) -> tag 2 result res_data=0, res_is_store=1; next cycle tag 3 result res_data=0xDEADBEEF.
- Loads at 0x13 and 0x200 -> mem_memread never asserted; res_exc=1, res_data=0 for each.
- res_ready=0; enqueue 5 ops -> first completes into the slot, then count reaches 4 and in_ready=0. Raise res_ready -> ops drain one per cycle, in_ready rises the cycle after the first further dequeue, tags in order.
- Queue holds 3 ops including a head store 0x40 <= 7; assert flush one cycle -> mem_memwrite=0, count=0, res_valid=0. A following load 0x40 returns 16 (store not committed).
- Assert reset with count=2 and res_valid=1 -> next cycle count=0, res_valid=0, in_ready=1, both memory strobes 0.
